// File: rtl/ex_div.sv
// ex_div: iterative restoring 32-bit divider for RV32M DIV/DIVU/REM/REMU in EX.
// Optional macro DIV_EARLY_EXIT_EN: 1-cycle result when |divisor| > |dividend|.
module ex_div #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        rem_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        stallreq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  counter_q, counter_d;
  logic [32:0] prem_q, prem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        rem_op_q, rem_op_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [31:0] dvd_mag, dvs_mag;
  logic [33:0] shifted, diff;
  logic        q_bit;
  logic [31:0] q_fix, r_fix;

  assign dvd_mag = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign dvs_mag = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // 34-bit trial difference: the shifted partial remainder can exceed 2^32.
  assign shifted = {prem_q, quot_q[31]};
  assign diff    = shifted - {2'b00, dvsr_q};
  assign q_bit   = ~diff[33];

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    prem_d    = prem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_op_d  = rem_op_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    q_fix     = 32'd0;
    r_fix     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == 32'd0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = rem_op ? dividend : 32'hFFFF_FFFF;
          end else if (signed_op && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = rem_op ? 32'd0 : 32'h8000_0000;
          end
`ifdef DIV_EARLY_EXIT_EN
          // A zero dividend with a nonzero divisor also satisfies this compare.
          else if (dvs_mag > dvd_mag) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = rem_op ? dividend : 32'd0;
          end
`endif
          else begin
            state_d   = S_CALC;
            busy_d    = 1'b1;
            counter_d = 5'd0;
            prem_d    = 33'd0;
            quot_d    = dvd_mag;
            dvsr_d    = dvs_mag;
            q_neg_d   = signed_op & (dividend[31] ^ divisor[31]);
            r_neg_d   = signed_op & dividend[31];
            rem_op_d  = rem_op;
          end
        end
      end

      S_CALC: begin
        prem_d    = q_bit ? diff[32:0] : shifted[32:0];
        quot_d    = {quot_q[30:0], q_bit};
        counter_d = counter_q + 5'd1;
        if (counter_q == 5'(CYCLES - 1)) begin
          q_fix    = q_neg_q ? (~quot_d + 32'd1) : quot_d;
          r_fix    = r_neg_q ? (~prem_d[31:0] + 32'd1) : prem_d[31:0];
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = rem_op_q ? r_fix : q_fix;
        end else begin
          busy_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (annul) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      counter_q <= 5'd0;
      prem_q    <= 33'd0;
      quot_q    <= 32'd0;
      dvsr_q    <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_op_q  <= 1'b0;
      result_q  <= 32'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      prem_q    <= prem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_op_q  <= rem_op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign stallreq = rst & (((state_q == S_IDLE) & start & ~annul) | (state_q == S_CALC));

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors with hand-computed results for ex_div.
// Expected latencies follow DIV_EARLY_EXIT_EN when it is defined for the build.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic        rem_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stallreq;

  int errors;
  int checks;
  logic [31:0] last_res;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = 33;
`endif

  ex_div #(.CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_op(signed_op),
    .rem_op(rem_op),
    .dividend(dividend),
    .divisor(divisor),
    .annul(annul),
    .result(result),
    .done(done),
    .busy(busy),
    .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one op at a negedge, holds start until done, checks result and timing.
  task automatic applyStimulus(input string tag, input logic s_op, input logic r_op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stall_cnt;
    int busy_cnt;
    bit got;
    @(negedge clk);
    start = 1'b1; signed_op = s_op; rem_op = r_op; dividend = a; divisor = b;
    lat = 0; stall_cnt = 0; busy_cnt = 0; got = 1'b0;
    while (lat < 40 && !got) begin
      #1;
      if (stallreq) stall_cnt++;
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " result"}, result, exp_res);
    checkOutput({tag, " stallreq in done"}, {31'd0, stallreq}, 32'd0);
    checkOutput({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    start = 1'b0;
    last_res = exp_res;
  endtask

  initial begin
    int done_cnt;
    errors = 0; checks = 0; last_res = 32'd0;
    rst = 1'b0; start = 1'b0; signed_op = 1'b0; rem_op = 1'b0;
    dividend = 32'd0; divisor = 32'd0; annul = 1'b0;

    #12;
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset stallreq", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus("divu 100/7",    1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);
    applyStimulus("remu 100/7",    1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33);
    applyStimulus("div -7/2",      1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    applyStimulus("rem -7/2",      1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    applyStimulus("div 7/-2",      1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    applyStimulus("rem 7/-2",      1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    applyStimulus("div -7/-2",     1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
    applyStimulus("divu max/1",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    applyStimulus("divu max/max-1",1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    applyStimulus("remu max/max-1",1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    applyStimulus("div 5/0",       1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("remu 5/0",      1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 1);
    applyStimulus("div ovf",       1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem ovf",       1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    applyStimulus("divu 3/10",     1'b0, 1'b0, 32'd3, 32'd10, 32'd0, EE_LAT);
    applyStimulus("remu 3/10",     1'b0, 1'b1, 32'd3, 32'd10, 32'd3, EE_LAT);
    applyStimulus("rem -3/10",     1'b1, 1'b1, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EE_LAT);
    applyStimulus("div 0/5",       1'b1, 1'b0, 32'd0, 32'd5, 32'd0, EE_LAT);
    applyStimulus("remu 1000/7",   1'b0, 1'b1, 32'd1000, 32'd7, 32'd6, 33);

    // Annul in cycle t+10 of a long divide.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; rem_op = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    #1;
    checkOutput("annul busy", {31'd0, busy}, 32'd0);
    checkOutput("annul stallreq", {31'd0, stallreq}, 32'd0);
    checkOutput("annul result kept", result, last_res);
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("annul no done", 32'(done_cnt), 32'd0);
    applyStimulus("divu 9/3 after annul", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; rem_op = 1'b0; dividend = 32'd500; divisor = 32'd3;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0; start = 1'b0;
    #1;
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    checkOutput("midreset result", result, 32'd0);
    checkOutput("midreset stallreq", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("post reset no done", 32'(done_cnt), 32'd0);
    applyStimulus("divu 100/7 after reset", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit integer divider for the EX stage, covering RV32M DIV, DIVU, REM and REMU. It is the consumer of the operands latched by the ID/EX pipeline register. While a division is in flight it raises a stall request to the pipeline control, which freezes the ID/EX register until the result is ready. The ALU result mux selects its result in the cycle `done` is high.

## Interface
Parameters:
- `CYCLES`, 32: iteration count; fixed at the operand width.

Ports:
- `clk`, in, 1: core clock; all state on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: a divide-class op is present in EX. Held high by EX for the whole stall.
- `signed_op`, in, 1: 1 selects DIV/REM; 0 selects DIVU/REMU.
- `rem_op`, in, 1: 1 returns the remainder; 0 returns the quotient.
- `dividend`, in, 32: EX operand 1 (`ex_opv1`).
- `divisor`, in, 32: EX operand 2 (`ex_opv2`).
- `annul`, in, 1: flush from pipeline control. It kills any operation in flight.
- `result`, out, 32: registered quotient or remainder; valid only while `done` is high.
- `done`, out, 1: registered; high for exactly one cycle per completed operation.
- `busy`, out, 1: registered; high in CALC.
- `stallreq`, out, 1: combinational stall request to pipeline control.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating.
  - DONE: result presented.
- IDLE, `start`=1, `annul`=0: operands, `signed_op` and `rem_op` are captured; the inputs are not used again until the next operation.
  - Divisor = 0 → DONE. Quotient = 0xFFFFFFFF, remainder = dividend (both signednesses).
  - `signed_op` with dividend 0x80000000 and divisor 0xFFFFFFFF → DONE. Quotient = 0x80000000, remainder = 0.
  - Otherwise: take magnitudes (two's-complement negate of negative operands when `signed_op`), clear the 33-bit partial remainder and the 5-bit counter, then go to CALC.
- CALC, each cycle (restoring division):
  - Shift the partial remainder left and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If the difference is non-negative, keep it and set the quotient bit to 1; otherwise quotient bit is 0.
  - After iteration 31 (counter = 31) → DONE.
- Entering DONE, sign fix-up when `signed_op`:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - `result` loads the quotient or remainder per `rem_op`; `done` = 1.
- DONE → IDLE unconditionally. `start` is ignored in DONE because it still belongs to the completing instruction.
- `stallreq` = `rst` & ((IDLE & `start` & ~`annul`) | CALC).
  - It is 0 in DONE so the pipeline advances on the edge that closes DONE.
- `annul` = 1 in any state → IDLE on the next edge. No `done` pulse is produced, `result` is unchanged and `busy` drops.
- `annul` takes priority over `start` and over CALC completion.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `result` 0x00000000, `done` 0, `busy` 0, counter 0, partial remainder 0. `stallreq` is forced to 0.
- Reset mid-CALC aborts the operation immediately. No `done` pulse follows release.
- Normal path: `start` sampled in cycle t → `busy` high in t+1..t+32 → `done` high in t+33. `stallreq` is high in t..t+32.
- Fast path (divide by zero, signed overflow, early exit): `start` in t → `done` in t+1. `stallreq` is high only in t.
- Back-to-back divides: the next `start` can be accepted in the cycle after DONE, at the earliest t+34.
- `done` and `result` are registered; there is no combinational path from inputs to `result`.

## Configuration
- `DIV_EARLY_EXIT_EN` defined:
  - In IDLE, if the divisor magnitude is greater than the dividend magnitude (and the divisor is nonzero), go straight to DONE with quotient 0 and remainder = dividend, in 1-cycle latency.
  - Zero dividend with a nonzero divisor takes the same path.
- `DIV_EARLY_EXIT_EN` undefined: these cases run the full 32-cycle CALC. Results are bit-identical; only latency differs.

## Test plan
- DIVU 100 / 7 → `done` at t+33; quotient 14; REMU 2; `stallreq` high for 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- DIV 5 / 0 → quotient 0xFFFFFFFF at t+1. REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, REM 0, `done` at t+1.
- DIVU 3 / 10: with `DIV_EARLY_EXIT_EN` → quotient 0 at t+1; without it → quotient 0 at t+33.
- `annul` at t+10 of a divide → IDLE at t+11, no `done` pulse, `stallreq` 0. A new DIVU 9 / 3 started at t+12 → quotient 3 at t+45.
- `rst` pulsed low at t+20 → `busy`, `done` and `result` are 0 immediately. After release with `start` low, `done` stays 0.
